// File: rtl/handshake_fifo_pkg.sv
// Shared handshake payload types and limits used by the handshake interface and
// every block built on it.
package handshake_fifo_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned HS_MIN_DEPTH = 2;
  localparam int unsigned HS_MAX_DEPTH = 64;

endpackage

// File: rtl/handshake_if.sv
// Valid/ready handshake bundle. The sender drives valid and data, and the
// receiver drives ready.
interface handshake_if
  import handshake_fifo_pkg::*;
#(
  parameter type T = word_t
) ();

  logic valid;
  logic ready;
  T     data;

  modport sender   (output valid, output data, input  ready);
  modport receiver (input  valid, input  data, output ready);

endinterface

// File: rtl/handshake_fifo.sv
// Registered-output valid/ready FIFO with a flush input. It sustains one push and
// one pop per cycle, and the pointers wrap correctly for depths that are not
// powers of two.
module handshake_fifo
  import handshake_fifo_pkg::*;
#(
  parameter type T     = word_t,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  handshake_if.receiver              in_if,
  handshake_if.sender                out_if,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH-1);

  if (DEPTH < int'(HS_MIN_DEPTH) || DEPTH > int'(HS_MAX_DEPTH)) begin : g_bad_depth
    $error("handshake_fifo: DEPTH must be in 2..64");
  end

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          not_full;
  logic          not_empty;
  logic          push;
  logic          pop;

  // Handshake flags come only from the count register, so neither side sees a
  // combinational path from the other.
  assign not_full  = (count != FULL_COUNT);
  assign not_empty = (count != '0);

  assign in_if.ready  = not_full;
  assign out_if.valid = not_empty;
  assign out_if.data  = mem[rd_ptr];

  assign push = in_if.valid && not_full;
  assign pop  = out_if.ready && not_empty;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset. An entry is valid only while count covers it.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= in_if.data;
  end

endmodule
